// File: rtl/uart_tx_fifo.sv
// Word FIFO in front of a UART transmitter: buffers producer words and launches them one at a time.
// Optional drop counter enabled by defining UART_TX_FIFO_DROP_CNT_EN.
module uart_tx_fifo #(
   parameter int PAYLOAD_BITS = 8,
   parameter int DEPTH_LOG2   = 4,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_valid,
   input  logic [PAYLOAD_BITS-1:0] wr_data,
   output logic                    wr_ready,
   input  logic                    uart_tx_busy,
   output logic                    uart_tx_en,
   output logic [PAYLOAD_BITS-1:0] uart_tx_data,
   output logic [DEPTH_LOG2:0]     level,
   output logic                    full,
   output logic                    empty,
   output logic                    overflow,
   output logic [7:0]              drop_count
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam int TW    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_LAUNCH    = 2'd1;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

   localparam logic [TW-1:0]         TIMER_LAST = TW'(BUSY_TIMEOUT - 1);
   localparam logic [TW-1:0]         TIMER_ONE  = TW'(1);
   localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2:0]   LEVEL_ZERO = (DEPTH_LOG2 + 1)'(0);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

   logic [PAYLOAD_BITS-1:0] mem_r [0:DEPTH-1];
   logic [DEPTH_LOG2-1:0]   wr_ptr_r;
   logic [DEPTH_LOG2-1:0]   rd_ptr_r;
   logic [DEPTH_LOG2:0]     level_r;
   logic                    full_r;
   logic                    empty_r;
   logic                    overflow_r;
   logic [1:0]              state_r;
   logic [TW-1:0]           timer_r;
   logic                    tx_en_r;
   logic [PAYLOAD_BITS-1:0] tx_data_r;

   logic                    push_s;
   logic                    pop_s;
   logic [DEPTH_LOG2:0]     level_nxt_s;
   logic [1:0]              state_nxt_s;
   logic [TW-1:0]           timer_nxt_s;

   // Push/pop decisions, next occupancy and launcher next state.
   always_comb begin
      push_s      = wr_valid & ~full_r;
      pop_s       = (state_r == ST_IDLE) & ~empty_r & ~uart_tx_busy;
      level_nxt_s = level_r;
      state_nxt_s = state_r;
      timer_nxt_s = timer_r;

      if (push_s && !pop_s) begin
         level_nxt_s = level_r + LEVEL_ONE;
      end else if (pop_s && !push_s) begin
         level_nxt_s = level_r - LEVEL_ONE;
      end else begin
         level_nxt_s = level_r;
      end

      case (state_r)
         ST_IDLE: begin
            if (pop_s) begin
               state_nxt_s = ST_LAUNCH;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            state_nxt_s = ST_WAIT_BUSY;
            timer_nxt_s = {TW{1'b0}};
         end
         ST_WAIT_BUSY: begin
            // A transmitter that never acknowledges is treated as having sent the word.
            if (uart_tx_busy) begin
               state_nxt_s = ST_WAIT_DONE;
            end else if (timer_r == TIMER_LAST) begin
               state_nxt_s = ST_IDLE;
            end else begin
               timer_nxt_s = timer_r + TIMER_ONE;
            end
         end
         ST_WAIT_DONE: begin
            if (!uart_tx_busy) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WAIT_DONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Pointers, status flags, launcher state and the launch register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
         rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
         level_r    <= LEVEL_ZERO;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         overflow_r <= 1'b0;
         state_r    <= ST_IDLE;
         timer_r    <= {TW{1'b0}};
         tx_en_r    <= 1'b0;
         tx_data_r  <= {PAYLOAD_BITS{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r  <= rd_ptr_r + PTR_ONE;
            tx_data_r <= mem_r[rd_ptr_r];
         end
         level_r    <= level_nxt_s;
         full_r     <= (level_nxt_s == LEVEL_FULL);
         empty_r    <= (level_nxt_s == LEVEL_ZERO);
         overflow_r <= wr_valid & full_r;
         state_r    <= state_nxt_s;
         timer_r    <= timer_nxt_s;
         tx_en_r    <= pop_s;
      end
   end

   // Storage array; no reset needed since occupancy tracking guards every read.
   always_ff @(posedge clk) begin
      if (!reset && push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

`ifdef UART_TX_FIFO_DROP_CNT_EN
   logic [7:0] drop_r;

   // Saturating count of words rejected because the FIFO was full.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_r <= 8'h00;
      end else if (wr_valid && full_r && (drop_r != 8'hFF)) begin
         drop_r <= drop_r + 8'h01;
      end
   end

   assign drop_count = drop_r;
`else
   assign drop_count = 8'h00;
`endif

   assign wr_ready     = ~full_r;
   assign uart_tx_en   = tx_en_r;
   assign uart_tx_data = tx_data_r;
   assign level        = level_r;
   assign full         = full_r;
   assign empty        = empty_r;
   assign overflow     = overflow_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model plus directed literal checks.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       uart_tx_busy;
   logic       uart_tx_en;
   logic [7:0] uart_tx_data;
   logic [4:0] level;
   logic       full;
   logic       empty;
   logic       overflow;
   logic [7:0] drop_count;

   always #5 clk = ~clk;

   uart_tx_fifo dut (
      .clk          (clk),
      .reset        (reset),
      .wr_valid     (wr_valid),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .uart_tx_busy (uart_tx_busy),
      .uart_tx_en   (uart_tx_en),
      .uart_tx_data (uart_tx_data),
      .level        (level),
      .full         (full),
      .empty        (empty),
      .overflow     (overflow),
      .drop_count   (drop_count)
   );

`ifdef UART_TX_FIFO_DROP_CNT_EN
   localparam logic [7:0] EXP_DROP_ONE = 8'h01;
   localparam logic [7:0] EXP_DROP_SAT = 8'hFF;
`else
   localparam logic [7:0] EXP_DROP_ONE = 8'h00;
   localparam logic [7:0] EXP_DROP_SAT = 8'h00;
`endif

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a word queue plus a description of where the launcher is in its handshake.
   logic [7:0] q[$];
   bit         m_on = 1'b0;
   bit         m_tx_en;
   bit         m_ovf;
   logic [7:0] m_tx_data;
   logic [7:0] m_drop;
   int         phase;     // 0 ready, 1 strobing, 2 awaiting busy, 3 transmitter busy
   int         waited;

   always @(posedge clk) begin
      bit full_now;
      bit pop_now;
      if (reset) begin
         q.delete();
         m_on = 1'b1; m_tx_en = 1'b0; m_ovf = 1'b0;
         m_tx_data = 8'h00; m_drop = 8'h00; phase = 0; waited = 0;
      end else if (m_on) begin
         full_now = (q.size() == 16);
         pop_now  = (phase == 0) && (q.size() > 0) && !uart_tx_busy;
         m_ovf    = wr_valid && full_now;
`ifdef UART_TX_FIFO_DROP_CNT_EN
         if (m_ovf && m_drop != 8'hFF) m_drop = m_drop + 8'h01;
`endif
         m_tx_en = pop_now;
         if (pop_now) m_tx_data = q.pop_front();
         if (wr_valid && !full_now) q.push_back(wr_data);
         if (pop_now) phase = 1;
         else if (phase == 1) begin phase = 2; waited = 0; end
         else if (phase == 2) begin
            if (uart_tx_busy) phase = 3;
            else begin
               waited++;
               if (waited == 4) phase = 0;
            end
         end
         else if (phase == 3 && !uart_tx_busy) phase = 0;
      end
   end

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      if (m_on) begin
         check("tx_en", uart_tx_en, m_tx_en);
         check("tx_data", uart_tx_data, m_tx_data);
         check("level", level, q.size());
         check("full", full, q.size() == 16);
         check("empty", empty, q.size() == 0);
         check("wr_ready", wr_ready, q.size() != 16);
         check("overflow", overflow, m_ovf);
         check("drop_count", drop_count, m_drop);
      end
   end

   // Transmitter emulation and launched-word capture.
   bit         auto_busy = 1'b0;
   int         dly = -1;
   int         hold = 0;
   logic [7:0] got[$];

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      if (uart_tx_en) got.push_back(uart_tx_data);
      if (auto_busy) begin
         if (uart_tx_busy) begin
            if (hold == 0) uart_tx_busy = 1'b0;
            else hold--;
         end else if (dly == 0) begin
            uart_tx_busy = 1'b1; hold = $urandom_range(0, 7); dly = -1;
         end else if (dly > 0) begin
            dly--;
         end
         if (uart_tx_en) begin
            dly = $urandom_range(0, 5);
            if (dly == 0 && !uart_tx_busy) begin
               uart_tx_busy = 1'b1; hold = $urandom_range(0, 7); dly = -1;
            end
         end
      end
   endtask

   task automatic quiesce();
      auto_busy = 1'b0; uart_tx_busy = 1'b0; dly = -1; wr_valid = 1'b0;
      repeat (10) tick();
   endtask

   initial begin
      int n;
      int rate;
      reset = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; uart_tx_busy = 1'b0;
      tick(); tick();
      reset = 1'b0;
      check("rst_level", level, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_wr_ready", wr_ready, 1);
      check("rst_tx_en", uart_tx_en, 0);
      check("rst_tx_data", uart_tx_data, 8'h00);
      check("rst_overflow", overflow, 0);
      check("rst_drop", drop_count, 8'h00);

      // Single word latency.
      wr_valid = 1'b1; wr_data = 8'hA5; tick();
      wr_valid = 1'b0;
      check("lat_level1", level, 1);
      check("lat_en_early", uart_tx_en, 0);
      tick();
      check("lat_en", uart_tx_en, 1);
      check("lat_data", uart_tx_data, 8'hA5);
      check("lat_level0", level, 0);
      tick();
      check("lat_en_once", uart_tx_en, 0);
      quiesce();

      // Fill while busy, overflow, then drain in order.
      uart_tx_busy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wr_valid = 1'b1; wr_data = 8'(i); tick();
      end
      check("fill_full", full, 1);
      check("fill_wr_ready", wr_ready, 0);
      check("fill_level", level, 16);
      wr_data = 8'hFF; tick();
      wr_valid = 1'b0;
      check("ovf_pulse", overflow, 1);
      check("ovf_drop", drop_count, EXP_DROP_ONE);
      tick();
      check("ovf_once", overflow, 0);
      check("ovf_level", level, 16);
      got.delete();
      uart_tx_busy = 1'b0; auto_busy = 1'b1;
      n = 0;
      while (got.size() < 16 && n < 2000) begin tick(); n++; end
      check("drain_count", got.size(), 16);
      for (int i = 0; i < 16 && i < got.size(); i++) check("drain_order", got[i], i);
      quiesce();

      // Busy never rises: launcher times out and moves on.
      wr_valid = 1'b1; wr_data = 8'h11; tick();
      wr_data = 8'h22; tick();
      wr_valid = 1'b0;
      check("to_en1", uart_tx_en, 1);
      check("to_data1", uart_tx_data, 8'h11);
      n = 0;
      do begin tick(); n++; end while (!uart_tx_en && n < 20);
      check("to_gap", n, 6);
      check("to_data2", uart_tx_data, 8'h22);
      quiesce();

      // Simultaneous push and pop at level 15, then drain across pointer wrap.
      uart_tx_busy = 1'b1;
      for (int i = 0; i < 15; i++) begin
         wr_valid = 1'b1; wr_data = 8'(8'h30 + i); tick();
      end
      check("sim_level15", level, 15);
      wr_data = 8'h99; uart_tx_busy = 1'b0; tick();
      wr_valid = 1'b0;
      check("sim_level_hold", level, 15);
      check("sim_en", uart_tx_en, 1);
      check("sim_data", uart_tx_data, 8'h30);
      auto_busy = 1'b1;
      n = 0;
      while (!empty && n < 2000) begin tick(); n++; end
      check("sim_drained", empty, 1);
      quiesce();

      // Reset while the transmitter is busy with five words pending.
      wr_valid = 1'b1; wr_data = 8'h40; tick();
      wr_valid = 1'b0; tick();
      uart_tx_busy = 1'b1; tick(); tick();
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1; wr_data = 8'(8'h50 + i); tick();
      end
      check("mid_level5", level, 5);
      reset = 1'b1; wr_data = 8'h77; tick();
      check("mid_level0", level, 0);
      check("mid_empty", empty, 1);
      check("mid_en", uart_tx_en, 0);
      reset = 1'b0; wr_valid = 1'b0; uart_tx_busy = 1'b0;
      n = 0;
      repeat (20) begin tick(); if (uart_tx_en) n++; end
      check("mid_no_launch", n, 0);

      // Drop counter saturation.
      uart_tx_busy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wr_valid = 1'b1; wr_data = 8'(i); tick();
      end
      repeat (300) tick();
      wr_valid = 1'b0; tick();
      check("drop_sat", drop_count, EXP_DROP_SAT);
      reset = 1'b1; tick();
      reset = 1'b0; uart_tx_busy = 1'b0;

      // Randomised traffic against the model.
      auto_busy = 1'b1;
      for (int p = 0; p < 8; p++) begin
         rate = $urandom_range(5, 95);
         repeat (500) begin
            wr_valid = ($urandom_range(0, 99) < rate);
            wr_data  = 8'($urandom_range(0, 255));
            reset    = ($urandom_range(0, 599) == 0);
            tick();
         end
      end
      reset = 1'b0; wr_valid = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 8, width of one UART data word.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 words (16).
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 4, max cycles to wait for uart_tx_busy rise after a launch.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wr_valid  input  1  producer presents a word this cycle (e.g. uart_rx_valid).
REQ-007 wr_data  input  PAYLOAD_BITS  word to enqueue.
REQ-008 wr_ready  output  1  FIFO can accept a word; equals !full.
REQ-009 uart_tx_busy  input  1  downstream uart_tx is transmitting.
REQ-010 uart_tx_en  output  1  one-cycle launch strobe to uart_tx.
REQ-011 uart_tx_data  output  PAYLOAD_BITS  word being launched; registered.
REQ-012 level  output  DEPTH_LOG2+1  current number of stored words.
REQ-013 full / empty  output  1 each  level == 2**DEPTH_LOG2 / level == 0.
REQ-014 overflow  output  1  one-cycle pulse when wr_valid arrives while full.
REQ-015 drop_count  output  8  dropped-word counter (see Configuration).

Function
REQ-016 SHALL accept a write at an edge iff wr_valid && !full at that edge; write pointer advances, wrapping modulo depth.
REQ-017 SHALL discard a word offered while full, contents unchanged, and pulse overflow high for exactly the following cycle.
REQ-018 SHALL run FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE -> LAUNCH when !empty && !uart_tx_busy; at that edge pop head word into uart_tx_data and advance read pointer (wraps).
REQ-020 LAUNCH: uart_tx_en = 1 for exactly this one cycle; unconditionally -> WAIT_BUSY.
REQ-021 WAIT_BUSY: -> WAIT_DONE when uart_tx_busy = 1; -> IDLE after BUSY_TIMEOUT cycles without busy (word considered sent).
REQ-022 WAIT_DONE: -> IDLE when uart_tx_busy = 0.
REQ-023 uart_tx_en SHALL be 0 in every state except LAUNCH.
REQ-024 uart_tx_data SHALL hold its value from the pop until the next pop.
REQ-025 Latency: a word written at edge N into an empty FIFO with FSM IDLE and busy low SHALL see uart_tx_en high in the cycle following edge N+1.
REQ-026 Simultaneous accepted write and pop at one edge: both occur, level unchanged.
REQ-027 Write while full in same edge as pop: write still rejected (full sampled pre-edge), overflow pulses.
REQ-028 level, full, empty SHALL be registered and consistent with pointers every cycle; level never exceeds 2**DEPTH_LOG2.

Reset
REQ-029 At a reset edge: pointers, level = 0, empty = 1, full = 0, wr_ready = 1, FSM = IDLE, uart_tx_en = 0, uart_tx_data = 0, overflow = 0, drop_count = 0.
REQ-030 Reset mid-transmission SHALL drop all stored words and the in-flight handshake; no uart_tx_en until a new write after reset deasserts.
REQ-031 Inputs SHALL be ignored while reset = 1.

Configuration
REQ-032 Macro UART_TX_FIFO_DROP_CNT_EN defined: drop_count increments on each rejected write (REQ-017), saturating at 8'hFF.
REQ-033 Macro undefined: drop_count tied to 8'h00, counter logic absent; overflow pulse unaffected.

Verification
REQ-034 Reset, write 8'hA5 with busy low -> uart_tx_en one cycle at 2nd edge after write, uart_tx_data = 8'hA5, level 1->0.
REQ-035 Hold busy high, write 16 words 8'h00..8'h0F, then 17th 8'hFF -> full = 1, wr_ready = 0, overflow pulses once, drop_count = 1 (macro on) / 0 (off); release busy -> words emitted in order 00..0F, one launch per busy low/high/low cycle.
REQ-036 Fill to 15, then write while a pop occurs same edge -> level stays 15; continue past pointer wrap, data order preserved.
REQ-037 Launch with busy never rising -> FSM returns IDLE after 4 cycles in WAIT_BUSY; next word launches.
REQ-038 Assert reset during WAIT_DONE with 5 words stored -> next cycle level = 0, empty = 1, uart_tx_en = 0; no launch after reset release without writes.
REQ-039 Macro on: 300 rejected writes -> drop_count = 8'hFF, no wrap.
